nand_flash_ctrl: RTL

Host-side sequencer for the nand_flash array. It accepts one whole-block erase, whole-page program or whole-page read request at a time over a req/ack handshake, and drives the array's cmd/blk/page/din/wr_en pins cycle by cycle. Programs and reads always transfer exactly PAGE_SIZE bytes, so the array's internal wr_ptr and rd_ptr wrap back to 0 after every operation. It tracks erase-before-program state per page and rejects illegal requests.

---
 rtl/nand_pkg.sv | 30 +++
 rtl/nand_flash_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/nand_pkg.sv
// ============================================================================
// Module   : nand_pkg
// Brief    : Shared op/cmd encodings, controller state enum, array geometry.
// Revision : 1.0
// ============================================================================
`default_nettype none

package nand_pkg;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_ERASE = 2'b01;
    localparam logic [1:0] OP_PROG  = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    localparam int DEF_BLOCKS    = 4;
    localparam int DEF_PAGES     = 4;
    localparam int DEF_PAGE_SIZE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ERASE  = 3'd1,
        ST_PROG   = 3'd2,
        ST_READ   = 3'd3,
        ST_RDRAIN = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/nand_flash_ctrl.sv
// ============================================================================
// Module   : nand_flash_ctrl
// Brief    : Host-side erase/program/read sequencer for the nand_flash array.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nand_flash_ctrl
    import nand_pkg::*;
#(
    parameter int BLOCKS    = DEF_BLOCKS,
    parameter int PAGES     = DEF_PAGES,
    parameter int PAGE_SIZE = DEF_PAGE_SIZE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [1:0] op,
    input  logic [7:0] req_blk,
    input  logic [7:0] req_page,
    output logic       ack,
    output logic       busy,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       err,
    output logic [1:0] f_cmd,
    output logic [7:0] f_blk,
    output logic [7:0] f_page,
    output logic [7:0] f_din,
    output logic       f_wr_en,
    input  logic [7:0] f_dout
);

    localparam int CNT_W = $clog2(PAGE_SIZE) + 1;
    localparam int NBITS = BLOCKS * PAGES;
    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    state_e             state_q, state_d;
    logic [7:0]         blk_q, blk_d;
    logic [7:0]         page_q, page_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [NBITS-1:0]   bitmap_q, bitmap_d;

    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   cur_idx;
    logic [IDX_W-1:0]   erase_idx;
    logic               reject;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            blk_q    <= '0;
            page_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            bitmap_q <= '0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            page_q   <= page_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            bitmap_q <= bitmap_d;
        end
    end

    always_comb begin
        req_idx   = IDX_W'(int'(req_blk) * PAGES + int'(req_page));
        cur_idx   = IDX_W'(int'(blk_q) * PAGES + int'(page_q));
        erase_idx = IDX_W'(int'(blk_q) * PAGES + int'(cnt_q));
        // Bitmap is only consulted once the address is known to be in range.
        reject    = (int'(req_blk) >= BLOCKS) ||
                    ((op != OP_ERASE) && (int'(req_page) >= PAGES)) ||
                    ((op == OP_PROG) && bitmap_q[req_idx]);
    end

    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        page_d   = page_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        bitmap_d = bitmap_q;
        ack      = 1'b0;
        busy     = (state_q != ST_IDLE);
        wr_ready = 1'b0;
        rd_data  = 8'h00;
        rd_valid = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        f_cmd    = OP_IDLE;
        f_blk    = 8'h00;
        f_page   = 8'h00;
        f_din    = 8'h00;
        f_wr_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req && (op != OP_IDLE)) begin
                    ack    = 1'b1;
                    blk_d  = req_blk;
                    page_d = req_page;
                    cnt_d  = '0;
                    err_d  = reject;
                    if (reject) begin
                        state_d = ST_DONE;
                    end else begin
                        case (op)
                            OP_ERASE: state_d = ST_ERASE;
                            OP_PROG:  state_d = ST_PROG;
                            default:  state_d = ST_READ;
                        endcase
                    end
                end
            end
            ST_ERASE: begin
                f_cmd               = OP_ERASE;
                f_blk               = blk_q;
                f_page              = 8'(cnt_q);
                bitmap_d[erase_idx] = 1'b0;
                cnt_d               = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PAGES - 1)) state_d = ST_DONE;
            end
            ST_PROG: begin
                f_cmd    = OP_PROG;
                f_blk    = blk_q;
                f_page   = page_q;
                wr_ready = 1'b1;
                f_wr_en  = wr_valid;
                f_din    = wr_data;
                if (wr_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(PAGE_SIZE - 1)) begin
                        bitmap_d[cur_idx] = 1'b1;
                        state_d           = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                f_cmd  = OP_READ;
                f_blk  = blk_q;
                f_page = page_q;
                // Array dout lags the read command by one cycle.
                if (cnt_q != '0) begin
                    rd_valid = 1'b1;
                    rd_data  = f_dout;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PAGE_SIZE - 1)) state_d = ST_RDRAIN;
            end
            ST_RDRAIN: begin
                rd_valid = 1'b1;
                rd_data  = f_dout;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire
